// File: rtl/la_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : la_pkg                                                        |
// | Description: Shared capture-controller types and circular pointer helper.  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package la_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2,
        DUMP    = 2'd3
    } cap_state_t;

    // Buffer depth need not be a power of two, so the wrap is an explicit compare.
    function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input int unsigned entries);
        return (addr == entries - 1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/circ_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : circ_ptr                                                      |
// | Description: Circular address pointer with clear, load and wrapping inc.   |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module circ_ptr
    import la_pkg::*;
#(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic [LOG2-1:0] ld_val,
    input  logic            inc,
    output logic [LOG2-1:0] ptr
);

    logic [LOG2-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (load) begin
            ptr_d = ld_val;
        end else if (inc) begin
            ptr_d = LOG2'(wrap_inc(32'(ptr_q), ENTRIES));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : capture_ctrl                                                  |
// | Description: Capture/dump sequencer for the RAMqueue sample buffer.        |
// |              CAPTURE_CTRL_TMO_EN adds a forced trigger after TMO_SMPL.     |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module capture_ctrl
    import la_pkg::*;
#(
    parameter int unsigned ENTRIES  = 384,
    parameter int unsigned LOG2     = 9
`ifdef CAPTURE_CTRL_TMO_EN
    ,
    parameter int unsigned TMO_SMPL = 4096
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wrt_smpl,
    input  logic            start,
    input  logic            abort,
    input  logic            trig,
    input  logic [LOG2-1:0] trig_pos,
    input  logic            dump_req,
    input  logic            rd_adv,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic [LOG2-1:0] raddr,
    output logic            armed,
    output logic            triggered,
    output logic            capture_done,
    output logic            dump_done
`ifdef CAPTURE_CTRL_TMO_EN
    ,
    output logic            timed_out
`endif
);

    localparam logic [LOG2:0] c_full = (LOG2+1)'(ENTRIES);

    cap_state_t      state_q, state_d;
    logic            armed_q, armed_d;
    logic            triggered_q, triggered_d;
    logic            cap_done_q, cap_done_d;
    logic            dump_done_q, dump_done_d;
    logic [LOG2:0]   fill_cnt_q, fill_cnt_d;
    logic [LOG2:0]   rd_cnt_q, rd_cnt_d;
    logic [LOG2-1:0] post_cnt_q, post_cnt_d;

    logic            w_wclr;
    logic            w_rload;
    logic            w_rinc;
    logic            w_accept;
    logic            w_force;
    logic [LOG2:0]   w_arm_lvl;

    assign we        = (state_q == CAPTURE) && wrt_smpl;
    assign w_arm_lvl = c_full - {1'b0, trig_pos};

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        triggered_d = triggered_q;
        cap_done_d  = cap_done_q;
        dump_done_d = 1'b0;
        fill_cnt_d  = fill_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        post_cnt_d  = post_cnt_q;
        w_wclr      = 1'b0;
        w_rload     = 1'b0;
        w_rinc      = 1'b0;
        w_accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = CAPTURE;
                    w_wclr      = 1'b1;
                    fill_cnt_d  = '0;
                    post_cnt_d  = '0;
                    armed_d     = 1'b0;
                    triggered_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (wrt_smpl && (fill_cnt_q != c_full)) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
                if (fill_cnt_q >= w_arm_lvl) begin
                    armed_d = 1'b1;
                end
                w_accept = armed_q && !triggered_q && wrt_smpl && (trig || w_force);
                if (w_accept) begin
                    triggered_d = 1'b1;
                    post_cnt_d  = {{(LOG2-1){1'b0}}, 1'b1};
                end else if (triggered_q && wrt_smpl) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                end
                // The accepting sample itself counts, so trig_pos=1 completes on it.
                if ((w_accept || (triggered_q && wrt_smpl)) && (post_cnt_d == trig_pos)) begin
                    state_d     = DONE;
                    cap_done_d  = 1'b1;
                    triggered_d = 1'b0;
                    armed_d     = 1'b0;
                end
            end
            DONE: begin
                if (start) begin
                    state_d     = CAPTURE;
                    w_wclr      = 1'b1;
                    fill_cnt_d  = '0;
                    post_cnt_d  = '0;
                    cap_done_d  = 1'b0;
                end else if (dump_req) begin
                    state_d  = DUMP;
                    w_rload  = 1'b1;
                    rd_cnt_d = '0;
                end
            end
            DUMP: begin
                if (rd_adv) begin
                    w_rinc   = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_d == c_full) begin
                        state_d     = IDLE;
                        dump_done_d = 1'b1;
                        cap_done_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            armed_d     = 1'b0;
            triggered_d = 1'b0;
            cap_done_d  = 1'b0;
            dump_done_d = 1'b0;
            w_wclr      = 1'b0;
            w_rload     = 1'b0;
            w_rinc      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            cap_done_q  <= 1'b0;
            dump_done_q <= 1'b0;
            fill_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            post_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            triggered_q <= triggered_d;
            cap_done_q  <= cap_done_d;
            dump_done_q <= dump_done_d;
            fill_cnt_q  <= fill_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            post_cnt_q  <= post_cnt_d;
        end
    end

`ifdef CAPTURE_CTRL_TMO_EN
    localparam int unsigned TMO_W = $clog2(TMO_SMPL + 1);
    localparam logic [TMO_W-1:0] c_tmo_max = TMO_W'(TMO_SMPL);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timed_out_q;

    assign w_force = (tmo_cnt_q == c_tmo_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q   <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (armed_d && !armed_q) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == CAPTURE) && armed_q && !triggered_q && wrt_smpl && !w_force) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (abort || w_wclr) begin
                timed_out_q <= 1'b0;
            end else if (w_accept && w_force) begin
                timed_out_q <= 1'b1;
            end
        end
    end

    assign timed_out = timed_out_q;
`else
    assign w_force = 1'b0;
`endif

    circ_ptr #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_wptr (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_wclr),
        .load   (1'b0),
        .ld_val ({LOG2{1'b0}}),
        .inc    (we),
        .ptr    (waddr)
    );

    // In DONE the write pointer rests on the oldest sample, so the dump starts there.
    circ_ptr #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_rptr (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .load   (w_rload),
        .ld_val (waddr),
        .inc    (w_rinc),
        .ptr    (raddr)
    );

    assign armed        = armed_q;
    assign triggered    = triggered_q;
    assign capture_done = cap_done_q;
    assign dump_done    = dump_done_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_capture_ctrl                                               |
// | Description: Directed self-checking bench for capture_ctrl (384 x 9).      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_capture_ctrl;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
`ifdef CAPTURE_CTRL_TMO_EN
    localparam int WRAP_TRIG = 290;
    localparam int EARLY_N   = 270;
`else
    localparam int WRAP_TRIG = 500;
    localparam int EARLY_N   = 300;
`endif
    localparam int WRAP_LAST = WRAP_TRIG + 99;
    localparam int WRAP_END  = WRAP_LAST % ENTRIES;

    logic            clk = 1'b0;
    logic            rst, wrt_smpl, start, abort, trig, dump_req, rd_adv;
    logic [LOG2-1:0] trig_pos, waddr, raddr;
    logic            we, armed, triggered, capture_done, dump_done;
`ifdef CAPTURE_CTRL_TMO_EN
    logic            timed_out;
`endif

    int n_err = 0;
    int n_chk = 0;
    int we_cnt = 0;
    int dd_cnt = 0;
    int we0, dd0;

    capture_ctrl #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
`ifdef CAPTURE_CTRL_TMO_EN
        ,
        .TMO_SMPL(16)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wrt_smpl     (wrt_smpl),
        .start        (start),
        .abort        (abort),
        .trig         (trig),
        .trig_pos     (trig_pos),
        .dump_req     (dump_req),
        .rd_adv       (rd_adv),
        .we           (we),
        .waddr        (waddr),
        .raddr        (raddr),
        .armed        (armed),
        .triggered    (triggered),
        .capture_done (capture_done),
        .dump_done    (dump_done)
`ifdef CAPTURE_CTRL_TMO_EN
        ,
        .timed_out    (timed_out)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we)        we_cnt <= we_cnt + 1;
        if (dump_done) dd_cnt <= dd_cnt + 1;
    end

    task automatic t_check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wr(input logic t, input int gap);
        wrt_smpl = 1'b1;
        trig     = t;
        tick(1);
        wrt_smpl = 1'b0;
        tick(gap);
    endtask

    task automatic adv();
        rd_adv = 1'b1;
        tick(1);
        rd_adv = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; wrt_smpl = 1'b0; start = 1'b0; abort = 1'b0;
        trig = 1'b0; dump_req = 1'b0; rd_adv = 1'b0; trig_pos = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        t_check("rst_waddr", 32'(waddr), 0);
        t_check("rst_raddr", 32'(raddr), 0);
        t_check("rst_we", 32'(we), 0);
        t_check("rst_armed", 32'(armed), 0);
        t_check("rst_trig", 32'(triggered), 0);
        t_check("rst_done", 32'(capture_done), 0);
        t_check("rst_dd", 32'(dump_done), 0);

        // Basic capture: trig held high, one sample every 4th clock
        trig_pos = 9'd128;
        pulse_start();
        we0 = we_cnt;
        for (int i = 1; i <= 384; i++) begin
            wr(1'b1, 3);
            if (i == 255) t_check("basic_arm255", 32'(armed), 0);
            if (i == 256) begin
                t_check("basic_arm256", 32'(armed), 1);
                t_check("basic_notrig256", 32'(triggered), 0);
            end
            if (i == 257) t_check("basic_trig257", 32'(triggered), 1);
            if (i == 383) t_check("basic_done383", 32'(capture_done), 0);
        end
        t_check("basic_done", 32'(capture_done), 1);
        t_check("basic_trig_clr", 32'(triggered), 0);
        t_check("basic_arm_clr", 32'(armed), 0);
        t_check("basic_we_cnt", 32'(we_cnt - we0), 384);
        t_check("basic_waddr", 32'(waddr), 0);
        wrt_smpl = 1'b1;
        #1;
        t_check("done_we_held", 32'(we), 0);
        tick(1);
        wrt_smpl = 1'b0;
        t_check("done_waddr_frozen", 32'(waddr), 0);

        // Wrap: late trigger, pointer wraps before completion
        trig_pos = 9'd100;
        trig = 1'b0;
        pulse_start();
        t_check("wrap_done_clr", 32'(capture_done), 0);
        we0 = we_cnt;
        for (int i = 1; i <= WRAP_LAST; i++) begin
            wr(i >= WRAP_TRIG, 1);
            if (i == 383) t_check("wrap_waddr383", 32'(waddr), 383);
            if (i == 384) t_check("wrap_waddr0", 32'(waddr), 0);
            if (i == WRAP_TRIG - 1) t_check("wrap_notrig", 32'(triggered), 0);
            if (i == WRAP_TRIG) t_check("wrap_trig", 32'(triggered), 1);
            if (i == WRAP_LAST - 1) t_check("wrap_done_early", 32'(capture_done), 0);
        end
        trig = 1'b0;
        t_check("wrap_done", 32'(capture_done), 1);
        t_check("wrap_waddr_end", 32'(waddr), 32'(WRAP_END));
        t_check("wrap_we_cnt", 32'(we_cnt - we0), 32'(WRAP_LAST));

        // Dump oldest-first
        dd0 = dd_cnt;
        dump_req = 1'b1;
        tick(1);
        dump_req = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            t_check("dump_raddr", 32'(raddr), 32'((WRAP_END + i) % ENTRIES));
            if (i == ENTRIES - 1) t_check("dump_dd_early", 32'(dd_cnt - dd0), 0);
            adv();
        end
        t_check("dump_dd_once", 32'(dd_cnt - dd0), 1);
        t_check("dump_done_clr", 32'(capture_done), 0);
        t_check("dump_raddr_wrap", 32'(raddr), 32'(WRAP_END));
        adv();
        t_check("idle_rdadv_ign", 32'(raddr), 32'(WRAP_END));
        t_check("idle_dd_once", 32'(dd_cnt - dd0), 1);
        wrt_smpl = 1'b1;
        #1;
        t_check("idle_we", 32'(we), 0);
        tick(1);
        wrt_smpl = 1'b0;

        // Early trigger ignored, then abort on the last write
        trig_pos = 9'd128;
        pulse_start();
        for (int i = 1; i < EARLY_N; i++) begin
            wr(i == 10, 0);
        end
        trig = 1'b0;
        t_check("early_armed", 32'(armed), 1);
        t_check("early_notrig", 32'(triggered), 0);
        t_check("early_notdone", 32'(capture_done), 0);
        wrt_smpl = 1'b1;
        abort = 1'b1;
        #1;
        t_check("abort_we_same", 32'(we), 1);
        tick(1);
        wrt_smpl = 1'b0;
        abort = 1'b0;
        t_check("abort_waddr", 32'(waddr), 32'(EARLY_N % ENTRIES));
        t_check("abort_armed", 32'(armed), 0);
        t_check("abort_trig", 32'(triggered), 0);
        t_check("abort_done", 32'(capture_done), 0);
        wrt_smpl = 1'b1;
        #1;
        t_check("abort_idle_we", 32'(we), 0);
        tick(1);
        wrt_smpl = 1'b0;

        // trig_pos=1: trigger write completes the capture; then reset mid-dump
        trig_pos = 9'd1;
        pulse_start();
        for (int i = 1; i <= 384; i++) begin
            wr(1'b1, 1);
            if (i == 383) t_check("tp1_done383", 32'(capture_done), 0);
        end
        trig = 1'b0;
        t_check("tp1_done", 32'(capture_done), 1);
        t_check("tp1_waddr", 32'(waddr), 0);
        dd0 = dd_cnt;
        dump_req = 1'b1;
        tick(1);
        dump_req = 1'b0;
        for (int i = 0; i < 10; i++) adv();
        t_check("mid_dump_raddr", 32'(raddr), 10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        t_check("rst_dump_raddr", 32'(raddr), 0);
        t_check("rst_dump_waddr", 32'(waddr), 0);
        t_check("rst_dump_done", 32'(capture_done), 0);
        adv();
        tick(2);
        t_check("rst_dump_rdadv", 32'(raddr), 0);
        t_check("rst_dump_dd", 32'(dd_cnt - dd0), 0);

`ifdef CAPTURE_CTRL_TMO_EN
        trig = 1'b0;
        trig_pos = 9'd128;
        pulse_start();
        for (int i = 1; i <= 400; i++) begin
            wr(1'b0, 3);
            if (i == 272) begin
                t_check("tmo_notrig272", 32'(triggered), 0);
                t_check("tmo_flag272", 32'(timed_out), 0);
            end
            if (i == 273) begin
                t_check("tmo_trig273", 32'(triggered), 1);
                t_check("tmo_flag273", 32'(timed_out), 1);
            end
            if (i == 399) t_check("tmo_done399", 32'(capture_done), 0);
        end
        t_check("tmo_done400", 32'(capture_done), 1);
        t_check("tmo_flag_hold", 32'(timed_out), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        t_check("tmo_flag_abort", 32'(timed_out), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
